// File: rtl/sdrc_arb_pkg.sv
// rtl/sdrc_arb_pkg.sv - shared constants and state encoding for the SDRAM request arbiter
//   No ports. Provides:
//     IDX_W         requester index width
//     TAG_W         per-requester transaction tag width
//     SDR_REQ_ID_W  downstream request id width, {index, tag}
//     arb_state_t   arbiter FSM state encoding
package sdrc_arb_pkg;

  localparam int IDX_W        = 2;
  localparam int TAG_W        = 2;
  localparam int SDR_REQ_ID_W = IDX_W + TAG_W;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_HOLD = 2'b01,
    ARB_GAP  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/sdrc_rr_pick.sv
// rtl/sdrc_rr_pick.sv - combinational rotate-priority encoder
//   Ports:
//     req    in   N  request vector
//     ptr    in   W  index given highest priority this cycle
//     valid  out  1  at least one request asserted
//     idx    out  W  first asserted index scanning ptr, ptr+1, ... with wrap
module sdrc_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    logic [W-1:0] cand;
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 0; i < N; i++) begin
      // Modulo keeps the scan correct even when N is not a power of two.
      cand = W'((int'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sdrc_req_arb.sv
// rtl/sdrc_req_arb.sv - round-robin arbiter for the SDRAM controller application request port
//   Optional feature macro: SDRC_ARB_HIPRI_EN (requester 0 gets absolute priority).
//   Ports:
//     clk, reset_n                 clock (rising edge), asynchronous active-low reset
//     m_req[NUM_REQ]               per-requester level request
//     m_req_tag/addr/len           flattened per-requester fields, requester i at [i*W +: W]
//     m_req_wr_n/m_req_wrap        per-requester direction (0 = write) and wrap mode
//     m_req_ack[NUM_REQ]           one-hot single-cycle acceptance pulse to the winner
//     req, req_id, req_addr,
//     req_len, req_wr_n, req_wrap  latched request to the controller, req_id = {grant_idx, tag}
//     req_ack                      controller accepted the request
//     arb_busy                     arbiter not idle
//     grant_idx                    index of current or last grant
module sdrc_req_arb
  import sdrc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int APP_AW  = 26,
  parameter int APP_RW  = 9
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        m_req,
  input  logic [NUM_REQ*TAG_W-1:0]  m_req_tag,
  input  logic [NUM_REQ*APP_AW-1:0] m_req_addr,
  input  logic [NUM_REQ*APP_RW-1:0] m_req_len,
  input  logic [NUM_REQ-1:0]        m_req_wr_n,
  input  logic [NUM_REQ-1:0]        m_req_wrap,
  output logic [NUM_REQ-1:0]        m_req_ack,
  output logic                      req,
  output logic [SDR_REQ_ID_W-1:0]   req_id,
  output logic [APP_AW-1:0]         req_addr,
  output logic [APP_RW-1:0]         req_len,
  output logic                      req_wr_n,
  output logic                      req_wrap,
  input  logic                      req_ack,
  output logic                      arb_busy,
  output logic [IDX_W-1:0]          grant_idx
);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   tag_q;
  logic               zlen_q;
  logic [NUM_REQ-1:0] pick_vec;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [APP_RW-1:0]  win_len;
  logic               done;

`ifdef SDRC_ARB_HIPRI_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign pick_vec  = {m_req[NUM_REQ-1:1], 1'b0};
  assign win_valid = m_req[0] | pick_valid;
  assign win_idx   = m_req[0] ? '0 : pick_idx;
`else
  assign pick_vec  = m_req;
  assign win_valid = pick_valid;
  assign win_idx   = pick_idx;
`endif

  sdrc_rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
    .req   (pick_vec),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign win_len = m_req_len[int'(win_idx)*APP_RW +: APP_RW];

  // A zero-length grant completes on its own in the first HOLD cycle.
  assign done   = (state == ARB_HOLD) && (zlen_q || req_ack);
  assign req_id = {grant_idx, tag_q};

  always_comb begin
    m_req_ack            = '0;
    m_req_ack[grant_idx] = done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      tag_q     <= '0;
      zlen_q    <= 1'b0;
      req       <= 1'b0;
      req_addr  <= '0;
      req_len   <= '0;
      req_wr_n  <= 1'b0;
      req_wrap  <= 1'b0;
      arb_busy  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_valid) begin
            grant_idx <= win_idx;
            tag_q     <= m_req_tag[int'(win_idx)*TAG_W +: TAG_W];
            req_addr  <= m_req_addr[int'(win_idx)*APP_AW +: APP_AW];
            req_len   <= win_len;
            req_wr_n  <= m_req_wr_n[win_idx];
            req_wrap  <= m_req_wrap[win_idx];
            zlen_q    <= (win_len == '0);
            req       <= (win_len != '0);
            arb_busy  <= 1'b1;
            state     <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (done) begin
            req   <= 1'b0;
            state <= ARB_GAP;
`ifdef SDRC_ARB_HIPRI_EN
            if (grant_idx != '0) rr_ptr <= grant_idx + 1'b1;
`else
            rr_ptr <= grant_idx + 1'b1;
`endif
          end
        end
        ARB_GAP: begin
          arb_busy <= 1'b0;
          state    <= ARB_IDLE;
        end
        default: begin
          req      <= 1'b0;
          arb_busy <= 1'b0;
          state    <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_req_arb.sv
// tb/tb_sdrc_req_arb.sv - directed self-checking bench for sdrc_req_arb
//   Drives the requester side and the controller ack; checks the request port,
//   ack routing, round-robin order, zero-length handling and async reset.
module tb_sdrc_req_arb;

  localparam int N  = 4;
  localparam int AW = 26;
  localparam int RW = 9;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    m_req;
  logic [N*2-1:0]  m_req_tag;
  logic [N*AW-1:0] m_req_addr;
  logic [N*RW-1:0] m_req_len;
  logic [N-1:0]    m_req_wr_n;
  logic [N-1:0]    m_req_wrap;
  logic [N-1:0]    m_req_ack;
  logic            req;
  logic [3:0]      req_id;
  logic [AW-1:0]   req_addr;
  logic [RW-1:0]   req_len;
  logic            req_wr_n;
  logic            req_wrap;
  logic            req_ack;
  logic            arb_busy;
  logic [1:0]      grant_idx;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_tag [N];

  always #5 clk = ~clk;

  sdrc_req_arb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m_req      (m_req),
    .m_req_tag  (m_req_tag),
    .m_req_addr (m_req_addr),
    .m_req_len  (m_req_len),
    .m_req_wr_n (m_req_wr_n),
    .m_req_wrap (m_req_wrap),
    .m_req_ack  (m_req_ack),
    .req        (req),
    .req_id     (req_id),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wr_n   (req_wr_n),
    .req_wrap   (req_wrap),
    .req_ack    (req_ack),
    .arb_busy   (arb_busy),
    .grant_idx  (grant_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] tag, input logic [AW-1:0] addr,
                         input logic [RW-1:0] len, input logic wr_n, input logic wrap);
    m_req_tag[i*2 +: 2]   = tag;
    m_req_addr[i*AW +: AW] = addr;
    m_req_len[i*RW +: RW]  = len;
    m_req_wr_n[i]          = wr_n;
    m_req_wrap[i]          = wrap;
    exp_tag[i]             = tag;
  endtask

  // One full grant/ack/gap cycle with requests left as driven; ack taken two cycles after req.
  task automatic serve(input int idx);
    logic [1:0] i2;
    logic [3:0] oh;
    i2 = 2'(idx);
    oh = 4'b0001 << idx;
    step();
    chk("srv_req", 32'(req), 32'd1);
    chk("srv_grant", 32'(grant_idx), 32'(i2));
    chk("srv_id", 32'(req_id), 32'({i2, exp_tag[idx]}));
    step();
    chk("srv_hold", 32'(req), 32'd1);
    req_ack = 1'b1;
    #1;
    chk("srv_ack", 32'(m_req_ack), 32'(oh));
    step();
    req_ack = 1'b0;
    chk("srv_gap_req", 32'(req), 32'd0);
    chk("srv_gap_busy", 32'(arb_busy), 32'd1);
    step();
    chk("srv_idle_busy", 32'(arb_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    m_req      = '0;
    m_req_tag  = '0;
    m_req_addr = '0;
    m_req_len  = '0;
    m_req_wr_n = '0;
    m_req_wrap = '0;
    req_ack    = 1'b0;
    for (int i = 0; i < N; i++) exp_tag[i] = 2'b00;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    chk("rst_req", 32'(req), 32'd0);
    chk("rst_ack", 32'(m_req_ack), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_id", 32'(req_id), 32'd0);
    chk("rst_addr", 32'(req_addr), 32'd0);

    // Single requester 1
    set_req(1, 2'b11, 26'h0000100, 9'd8, 1'b1, 1'b0);
    m_req = 4'b0010;
    step();
    chk("s1_req", 32'(req), 32'd1);
    chk("s1_id", 32'(req_id), 32'h7);
    chk("s1_addr", 32'(req_addr), 32'h100);
    chk("s1_len", 32'(req_len), 32'd8);
    chk("s1_wr_n", 32'(req_wr_n), 32'd1);
    chk("s1_busy", 32'(arb_busy), 32'd1);
    chk("s1_noack", 32'(m_req_ack), 32'd0);
    step();
    step();
    chk("s1_hold", 32'(req), 32'd1);
    req_ack = 1'b1;
    #1;
    chk("s1_ack", 32'(m_req_ack), 32'h2);
    step();
    req_ack = 1'b0;
    m_req   = '0;
    chk("s1_drop", 32'(req), 32'd0);
    chk("s1_gap_busy", 32'(arb_busy), 32'd1);
    step();
    chk("s1_idle", 32'(arb_busy), 32'd0);

    // Stray ack in IDLE
    req_ack = 1'b1;
    #1;
    chk("stray_idle_ack", 32'(m_req_ack), 32'd0);
    step();
    req_ack = 1'b0;
    chk("stray_idle_busy", 32'(arb_busy), 32'd0);
    chk("stray_idle_req", 32'(req), 32'd0);

    // Zero-length on requester 2 (rr_ptr is 2)
    set_req(2, 2'b01, 26'h0ABCDEF, 9'd0, 1'b0, 1'b1);
    m_req = 4'b0100;
    step();
    chk("z_req", 32'(req), 32'd0);
    chk("z_grant", 32'(grant_idx), 32'd2);
    chk("z_ack", 32'(m_req_ack), 32'h4);
    chk("z_addr", 32'(req_addr), 32'h0ABCDEF);
    chk("z_wrap", 32'(req_wrap), 32'd1);
    m_req = '0;
    step();
    chk("z_gap_ack", 32'(m_req_ack), 32'd0);
    chk("z_gap_busy", 32'(arb_busy), 32'd1);
    chk("z_gap_req", 32'(req), 32'd0);
    req_ack = 1'b1;
    #1;
    chk("stray_gap_ack", 32'(m_req_ack), 32'd0);
    step();
    req_ack = 1'b0;
    chk("stray_gap_idle", 32'(arb_busy), 32'd0);

    // rr_ptr is now 3: requester 3 wins over 1 and 2
    set_req(0, 2'b10, 26'h0000040, 9'd4, 1'b1, 1'b0);
    set_req(1, 2'b01, 26'h0000080, 9'd2, 1'b0, 1'b0);
    set_req(2, 2'b11, 26'h00000C0, 9'd5, 1'b1, 1'b1);
    set_req(3, 2'b10, 26'h3FFFFFF, 9'd511, 1'b0, 1'b0);
    m_req = 4'b1110;
    step();
    chk("ptr3_grant", 32'(grant_idx), 32'd3);
    chk("ptr3_req", 32'(req), 32'd1);
    chk("ptr3_len", 32'(req_len), 32'd511);

    // Async reset during HOLD
    #3 reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_busy", 32'(arb_busy), 32'd0);
    chk("arst_grant", 32'(grant_idx), 32'd0);
    #1 reset_n = 1'b1;
    m_req = 4'b1000;
    step();
    chk("rearb_grant", 32'(grant_idx), 32'd3);
    chk("rearb_id", 32'(req_id), 32'hE);
    chk("rearb_req", 32'(req), 32'd1);
    req_ack = 1'b1;
    #1;
    chk("rearb_ack", 32'(m_req_ack), 32'h8);
    step();
    req_ack = 1'b0;
    m_req   = '0;
    step();

`ifdef SDRC_ARB_HIPRI_EN
    m_req = 4'b1001;
    serve(0);
    serve(0);
    serve(0);
    m_req = 4'b1000;
    serve(3);
`else
    // All four requesting continuously; rr_ptr is 0 after serving 3
    m_req = 4'b1111;
    serve(0);
    serve(1);
    serve(2);
    serve(3);
    serve(0);
`endif
    m_req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdrc_req_arb.md
Name: sdrc_req_arb

Overview:
- Round-robin arbiter that shares the single SDRAM controller application request port among NUM_REQ requesters (e.g. CPU I-fetch, CPU D-port, DMA, display).
- Registers the winning request, tags the downstream req_id with the requester index, holds the request until the controller's req_ack, then routes the ack back to the winner.
- Sits between the bus-side masters and the SDRAM controller's request-generation stage.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 in this revision.
- IDX_W, 2, requester index width; equals log2(NUM_REQ).
- TAG_W, 2, per-requester tag width; IDX_W+TAG_W = 4 = SDR_REQ_ID_W.
- APP_AW, 26, application address width.
- APP_RW, 9, application request-length width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m_req  in  NUM_REQ  per-requester request; level, held until m_req_ack.
- m_req_tag  in  NUM_REQ*TAG_W  per-requester transaction tag, flattened (requester i at [i*TAG_W +: TAG_W]).
- m_req_addr  in  NUM_REQ*APP_AW  per-requester address, flattened.
- m_req_len  in  NUM_REQ*APP_RW  per-requester burst length, flattened.
- m_req_wr_n  in  NUM_REQ  0 = write, 1 = read.
- m_req_wrap  in  NUM_REQ  wrap-mode request.
- m_req_ack  out  NUM_REQ  one-hot single-cycle acceptance pulse.
- req  out  1  request to controller.
- req_id  out  4  {grant index, tag}.
- req_addr  out  APP_AW  latched address.
- req_len  out  APP_RW  latched length.
- req_wr_n  out  1  latched direction.
- req_wrap  out  1  latched wrap.
- req_ack  in  1  controller accepted request.
- arb_busy  out  1  high whenever not in ARB_IDLE.
- grant_idx  out  IDX_W  index of current or last grant.

Behaviour:
- Reset (async assert, sync release): state ARB_IDLE; req=0, m_req_ack=0, arb_busy=0, grant_idx=0; rr_ptr=0; all latched request fields=0.
- State machine:
  - ARB_IDLE: if any m_req, select a winner, latch its fields, set grant_idx, go to ARB_HOLD. req rises on the next clk edge (1-cycle latency from m_req to req). No requests: stay.
  - ARB_HOLD: req=1 and all outputs stable. On req_ack: req cleared on the same edge, rr_ptr<=grant_idx+1 (mod NUM_REQ), go to ARB_GAP.
  - ARB_GAP: one dead cycle so the winner can drop m_req before re-arbitration; always go to ARB_IDLE.
- Ack routing: m_req_ack[grant_idx] = req_ack & (state==ARB_HOLD); combinational, same cycle as req_ack; all other bits 0.
- Winner selection: first asserted m_req scanning rr_ptr, rr_ptr+1, ... with wrap-around at NUM_REQ-1 -> 0. Combinational; sampled only in ARB_IDLE.
- req_id = {grant_idx, latched tag}.
- Zero-length request (m_req_len==0):
  - Never forwarded to the controller.
  - Winner is latched; in ARB_HOLD, req stays 0 and m_req_ack[grant_idx] pulses for one cycle (the cycle after the grant) without req_ack.
  - Then ARB_GAP; rr_ptr advances as normal.
- req_ack outside ARB_HOLD: ignored, no m_req_ack, no state change.
- m_req deasserted mid-HOLD (protocol violation): the latched request still completes; ack is routed to that index.
- Requester asserting in ARB_GAP: served at the next ARB_IDLE, subject to rr order.
- Reset mid-HOLD: req drops asynchronously; the request is lost and the requester must re-issue.
- Latched request fields change only on the grant edge.

Optional Feature:
- Macro SDRC_ARB_HIPRI_EN.
- Defined: requester 0 has absolute priority. If m_req[0] is set in ARB_IDLE it wins regardless of rr_ptr, and rr_ptr is not updated after its ack. Requesters 1..3 rotate round-robin among themselves.
- Undefined: pure round-robin across all requesters; no extra logic.

Decomposition:
- Shared package sdrc_arb_pkg holds:
  - state encodings ARB_IDLE=2'b00, ARB_HOLD=2'b01, ARB_GAP=2'b10;
  - SDR_REQ_ID_W=4; IDX_W and TAG_W constants.
- One sub-module, sdrc_rr_pick: combinational rotate-priority encoder (inputs req vector and pointer; outputs valid and index). It is reused by future data-return arbiters.

Test Plan:
- Single requester: m_req=4'b0010, tag=2'b11, addr=26'h0000100, len=9'd8. Expect req=1 one cycle later, req_id=4'b0111; req_ack at cycle 5 gives m_req_ack=4'b0010 the same cycle; req=0 next cycle.
- All four requesting continuously, req_ack 2 cycles after each req. Expect grant order 0,1,2,3,0; exactly one ARB_GAP cycle between requests.
- Zero-length: m_req[2] with len=0. Expect req never asserted; m_req_ack=4'b0100 one cycle after the grant; rr_ptr=3 afterwards.
- Stray req_ack in ARB_IDLE and ARB_GAP. Expect no m_req_ack and no state change.
- reset_n low during ARB_HOLD. Expect req=0 asynchronously (before the next clk); after release, rr_ptr=0 and the pending m_req[3] is re-granted with req_id={2'd3, tag}.
- With SDRC_ARB_HIPRI_EN defined and m_req=4'b1001 held: requester 0 wins every arbitration while asserted; drop m_req[0] and requester 3 is granted next.
